// File: rtl/jcsa_seq_subtractor.sv
// jcsa_seq_subtractor
// Multi-cycle handshaked subtractor: diff = a - b - borrowin (mod 2^WIDTH).
// Evaluates one 4-bit carry-skip block per clock, LSB block first, using the
// identity a - b - bin = a + ~b + ~bin. borrowout is the inverted final carry.
//
// Parameters:
//   WIDTH       operand width, multiple of 4 and >= 8
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operands/borrowin valid (sampled only in IDLE)
//   in_ready    block can accept operands (IDLE only)
//   a, b        minuend, subtrahend
//   borrowin    borrow into bit 0
//   out_valid   diff/borrowout valid, held until out_ready
//   out_ready   consumer accepts the result
//   diff        a - b - borrowin modulo 2^WIDTH
//   borrowout   1 when a < b + borrowin (unsigned)
//   skip_count  number of blocks whose carry took the skip path
//
// Optional feature macro: JCSA_SKIP_STATS_EN
//   defined   -> skip_count counts skip-path blocks per operation
//   undefined -> skip_count is tied to zero, no counter logic
module jcsa_seq_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrowout,
  output logic [7:0]       skip_count
);

  localparam int NBLK = WIDTH / 4;
  localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBLK - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One 4-bit carry-skip block: returns {carry_out, sum[3:0]}.
  // When every bit propagates, the carry-in bypasses the ripple chain.
  function automatic logic [4:0] skip_block(input logic [3:0] a4,
                                            input logic [3:0] bn4,
                                            input logic       cin);
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] s;
    p    = a4 ^ bn4;
    c    = 5'd0;
    s    = 4'd0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = (a4[i] & bn4[i]) | (a4[i] & c[i]) | (bn4[i] & c[i]);
      s[i]   = p[i] ^ c[i];
    end
    return {((&p) ? cin : c[4]), s};
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] bn_r;       // subtrahend stored already inverted
  logic             carry_r;
  logic [IDXW-1:0]  idx_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrowout_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [3:0]       a_nib_s;
  logic [3:0]       bn_nib_s;
  logic [4:0]       blk_s;
  logic             accept_s;

  assign accept_s = in_valid & in_ready_r;
  assign a_nib_s  = a_r[{idx_r, 2'b00} +: 4];
  assign bn_nib_s = bn_r[{idx_r, 2'b00} +: 4];
  assign blk_s    = skip_block(a_nib_s, bn_nib_s, carry_r);

  // Next-state decode for the IDLE -> RUN -> DONE handshake sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (idx_r == LAST_IDX) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register and handshake flags, registered from the next state so
  // in_ready/out_valid are glitch-free and mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == S_IDLE);
      out_valid_r <= (state_nxt_s == S_DONE);
    end
  end

  // Operand capture and block-per-cycle evaluation of the difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= {WIDTH{1'b0}};
      bn_r        <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      idx_r       <= {IDXW{1'b0}};
      diff_r      <= {WIDTH{1'b0}};
      borrowout_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            a_r         <= a;
            bn_r        <= ~b;
            carry_r     <= ~borrowin;
            idx_r       <= {IDXW{1'b0}};
            diff_r      <= {WIDTH{1'b0}};
            borrowout_r <= 1'b0;
          end
        end
        S_RUN: begin
          diff_r[{idx_r, 2'b00} +: 4] <= blk_s[3:0];
          carry_r                     <= blk_s[4];
          if (idx_r == LAST_IDX) begin
            // Final carry of a + ~b + ~bin is the inverted borrow.
            borrowout_r <= ~blk_s[4];
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef JCSA_SKIP_STATS_EN
  logic [7:0] skip_count_r;

  // Count RUN cycles whose block carry took the skip path (all bits propagate).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_count_r <= 8'd0;
    end else if (accept_s) begin
      skip_count_r <= 8'd0;
    end else if ((state_r == S_RUN) && (&(a_nib_s ^ bn_nib_s))) begin
      skip_count_r <= skip_count_r + 8'd1;
    end
  end

  assign skip_count = skip_count_r;
`else
  assign skip_count = 8'd0;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign borrowout = borrowout_r;

endmodule

// File: tb/tb_jcsa_seq_subtractor.sv
// Self-checking bench for jcsa_seq_subtractor (WIDTH=16).
// Expected results come from plain arithmetic on the operands; directed
// cases additionally carry hand-computed literal results.
module tb_jcsa_seq_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrowin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrowout;
  logic [7:0]   skip_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_diff = 16'h0000;
  logic         exp_bo   = 1'b0;
  logic [7:0]   exp_sc   = 8'd0;
  logic         exp_live = 1'b0;

  jcsa_seq_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrowin   (borrowin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrowout  (borrowout),
    .skip_count (skip_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference model: plain unsigned arithmetic.
  function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin);
    int unsigned r;
    r = (int'(x) - int'(y) - int'(bin)) & 32'h0000_FFFF;
    return r[W-1:0];
  endfunction

  function automatic logic m_borrow(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin);
    return (int'(x) < (int'(y) + int'(bin)));
  endfunction

  // A block skips exactly when all bits propagate, i.e. the nibbles of a and b are equal.
  function automatic logic [7:0] m_skip(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [7:0] n;
    n = 8'd0;
    for (int k = 0; k < W / 4; k++) begin
      if (x[4*k +: 4] == y[4*k +: 4]) n = n + 8'd1;
    end
    return n;
  endfunction

  function automatic logic [7:0] eff_skip(input logic [7:0] s);
`ifdef JCSA_SKIP_STATS_EN
    return s;
`else
    return 8'd0 & s;
`endif
  endfunction

  // Compare process: result checked on every cycle it is presented.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("hs_exclusive", {31'd0, in_ready & out_valid}, 32'd0);
      if (out_valid === 1'b1) begin
        chk("out_valid_owner", {31'd0, out_valid}, {31'd0, exp_live});
        chk("diff", {16'd0, diff}, {16'd0, exp_diff});
        chk("borrowout", {31'd0, borrowout}, {31'd0, exp_bo});
        chk("skip_count", {24'd0, skip_count}, {24'd0, exp_sc});
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                        input logic [W-1:0] ed, input logic eb, input logic [7:0] es,
                        input int hold, input string tag);
    int n;
    int lat;
    @(negedge clk);
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    a        = ta;
    b        = tb_;
    borrowin = tbin;
    in_valid = 1'b1;
    exp_diff = ed;
    exp_bo   = eb;
    exp_sc   = eff_skip(es);
    exp_live = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    // Inputs are ignored outside IDLE; early out_ready has no effect.
    in_valid  = 1'($urandom_range(0, 1));
    a         = W'($urandom);
    b         = W'($urandom);
    borrowin  = 1'($urandom_range(0, 1));
    out_ready = 1'($urandom_range(0, 1));
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid === 1'b1) break;
      in_valid  = 1'($urandom_range(0, 1));
      a         = W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_latency"}, lat, 32'd4);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_live  = 1'b0;
    chk({tag, "_rel_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_rel_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0000;
    b         = 16'h0000;
    borrowin  = 1'b0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff", {16'd0, diff}, 32'd0);
    chk("rst_borrowout", {31'd0, borrowout}, 32'd0);
    chk("rst_skip", {24'd0, skip_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Model pinned against hand-computed values.
    chk("model_basic", {16'd0, m_diff(16'h1234, 16'h0034, 1'b0)}, 32'h1200);
    chk("model_under", {31'd0, m_borrow(16'h0000, 16'h0001, 1'b0)}, 32'd1);
    chk("model_skip", {24'd0, m_skip(16'hFFFF, 16'hFFFF)}, 32'd4);

    run_op(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 8'd2, 0, "basic");
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 8'd3, 2, "underflow");
    run_op(16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 8'd0, 1, "borrowin");
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 8'd4, 0, "fullskip");
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 8'd0, 10, "backpress");
    run_op(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b1, 8'd3, 0, "second");

    // Reset two cycles into an operation.
    @(negedge clk);
    a        = 16'hABCD;
    b        = 16'h1111;
    borrowin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_diff", {16'd0, diff}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_skip", {24'd0, skip_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 8'd2, 0, "after_rst");

    // Randomized operations, some with matching nibbles to exercise skips.
    for (int t = 0; t < 30; t++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) rb = ra ^ (W'($urandom) & 16'hF0F0);
      if (t == 0) rb = ra;
      run_op(ra, rb, rbin, m_diff(ra, rb, rbin), m_borrow(ra, rb, rbin),
             m_skip(ra, rb), $urandom_range(0, 3), "rand");
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
